dec_param_enable: RTL and testbench



---
 rtl/dec_param_enable.sv | 63 ++++++
 tb/tb_dec_param_enable.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/dec_param_enable.sv
// Registered binary-to-one-hot (or one-cold) decoder with enable.
// Define DEC_PARAM_ENABLE_HOLD_EN to keep the last decode on d while enab is low.
module dec_param_enable #(
  parameter int unsigned IN_W       = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_W-1:0]      inp,
  input  logic                 enab,
  output logic [(2**IN_W)-1:0] d,
  output logic                 valid,
  output logic [IN_W-1:0]      sel_q
);

  localparam int unsigned OUT_W = 2 ** IN_W;
  localparam logic [OUT_W-1:0] IDLE = {OUT_W{ACTIVE_LOW}};

  logic [OUT_W-1:0] hot;
  logic [OUT_W-1:0] d_d, d_q;
  logic             valid_d, valid_q;
  logic [IN_W-1:0]  sel_d, sel_r;

  always_comb begin
    hot      = '0;
    hot[inp] = 1'b1;
  end

  always_comb begin
    d_d     = d_q;
    valid_d = 1'b0;
    sel_d   = sel_r;
    if (enab) begin
      // Flipping the selected bit of IDLE covers both polarities.
      d_d     = IDLE ^ hot;
      valid_d = 1'b1;
      sel_d   = inp;
    end else begin
`ifdef DEC_PARAM_ENABLE_HOLD_EN
      d_d = d_q;
`else
      d_d = IDLE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q     <= IDLE;
      valid_q <= 1'b0;
      sel_r   <= '0;
    end else begin
      d_q     <= d_d;
      valid_q <= valid_d;
      sel_r   <= sel_d;
    end
  end

  assign d     = d_q;
  assign valid = valid_q;
  assign sel_q = sel_r;

endmodule

// File: tb/tb_dec_param_enable.sv
// Scoreboard bench for dec_param_enable: four instances (4-bit, 4-bit active-low,
// 2-bit, 1-bit) driven in lockstep with directed vectors.
module tb_dec_param_enable;

`ifdef DEC_PARAM_ENABLE_HOLD_EN
  localparam bit Hold = 1'b1;
`else
  localparam bit Hold = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enab = 1'b0;
  logic [3:0]  inp4 = '0;
  logic [1:0]  inp2 = '0;
  logic        inp1 = 1'b0;

  logic [15:0] d16, d16l;
  logic [3:0]  d4;
  logic [1:0]  d2;
  logic        v16, v16l, v4, v2;
  logic [3:0]  s16, s16l;
  logic [1:0]  s4;
  logic        s2;

  dec_param_enable #(.IN_W(4), .ACTIVE_LOW(1'b0)) u_main (
    .clk(clk), .rst(rst), .inp(inp4), .enab(enab), .d(d16), .valid(v16), .sel_q(s16)
  );
  dec_param_enable #(.IN_W(4), .ACTIVE_LOW(1'b1)) u_low (
    .clk(clk), .rst(rst), .inp(inp4), .enab(enab), .d(d16l), .valid(v16l), .sel_q(s16l)
  );
  dec_param_enable #(.IN_W(2), .ACTIVE_LOW(1'b0)) u_w2 (
    .clk(clk), .rst(rst), .inp(inp2), .enab(enab), .d(d4), .valid(v4), .sel_q(s4)
  );
  dec_param_enable #(.IN_W(1), .ACTIVE_LOW(1'b0)) u_w1 (
    .clk(clk), .rst(rst), .inp(inp1), .enab(enab), .d(d2), .valid(v2), .sel_q(s2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d16;
    logic [3:0]  d4;
    logic [1:0]  d2;
    logic        v;
    logic [3:0]  sel;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last16 = '0;
  logic [3:0]  last4 = '0;
  logic [1:0]  last2 = '0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected values are the default-build values; with hold enabled an enab=0
  // cycle instead expects the previous decode to persist.
  task automatic step(input logic r, input logic e, input logic [3:0] i4,
                      input logic [1:0] i2, input logic i1,
                      input logic [15:0] xd16, input logic [3:0] xd4, input logic [1:0] xd2,
                      input logic xv, input logic [3:0] xsel);
    exp_t x;
    @(negedge clk);
    rst  = r;
    enab = e;
    inp4 = i4;
    inp2 = i2;
    inp1 = i1;
    if (e && $isunknown({i4, i2, i1})) begin
      errors++;
      $display("FAIL stim_x: inp unknown while enab=1 at %0t", $time);
    end
    if (!r && !e && Hold) begin
      xd16 = last16;
      xd4  = last4;
      xd2  = last2;
    end
    last16 = xd16;
    last4  = xd4;
    last2  = xd2;
    x.d16 = xd16;
    x.d4  = xd4;
    x.d2  = xd2;
    x.v   = xv;
    x.sel = xsel;
    sb.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("d_main", d16, mon_e.d16);
      chk("d_low", d16l, ~mon_e.d16);
      chk("d_w2", {12'h0, d4}, {12'h0, mon_e.d4});
      chk("d_w1", {14'h0, d2}, {14'h0, mon_e.d2});
      chk("valid", {12'h0, v16, v16l, v4, v2}, {12'h0, {4{mon_e.v}}});
      chk("sel_q", {12'h0, s16}, {12'h0, mon_e.sel});
      if (v16) chk("onehot", 16'($countones(d16)), 16'd1);
    end
  end

  initial begin
    logic [3:0] c;
    // Reset held two cycles with an enabled code present.
    step(1, 1, 4'h7, 2'h3, 1'b1, 16'h0000, 4'h0, 2'h0, 0, 4'h0);
    step(1, 1, 4'h7, 2'h3, 1'b1, 16'h0000, 4'h0, 2'h0, 0, 4'h0);
    // Full sweep, one code per cycle.
    for (int i = 0; i < 16; i++) begin
      c = 4'(i);
      step(0, 1, c, c[1:0], c[0], 16'h0001 << c, 4'h1 << c[1:0], 2'h1 << c[0], 1, c);
    end
    // Enable drop.
    step(0, 1, 4'h5, 2'h1, 1'b1, 16'h0020, 4'h2, 2'h2, 1, 4'h5);
    step(0, 0, 4'hA, 2'h2, 1'b0, 16'h0000, 4'h0, 2'h0, 0, 4'h5);
    step(0, 0, 4'hA, 2'h2, 1'b0, 16'h0000, 4'h0, 2'h0, 0, 4'h5);
    // Reset pulse then code 3 (active-low copy sees FFFF then FFF7).
    step(1, 0, 4'h0, 2'h0, 1'b0, 16'h0000, 4'h0, 2'h0, 0, 4'h0);
    step(0, 1, 4'h3, 2'h3, 1'b0, 16'h0008, 4'h8, 2'h1, 1, 4'h3);
    // Mid-stream reset discards the code presented on the same edge.
    step(0, 1, 4'hF, 2'h3, 1'b1, 16'h8000, 4'h8, 2'h2, 1, 4'hF);
    step(1, 1, 4'h2, 2'h2, 1'b0, 16'h0000, 4'h0, 2'h0, 0, 4'h0);
    step(0, 1, 4'h2, 2'h2, 1'b0, 16'h0004, 4'h4, 2'h1, 1, 4'h2);
    // enab toggling every cycle.
    step(0, 1, 4'h9, 2'h1, 1'b1, 16'h0200, 4'h2, 2'h2, 1, 4'h9);
    step(0, 0, 4'h4, 2'h0, 1'b0, 16'h0000, 4'h0, 2'h0, 0, 4'h9);
    step(0, 1, 4'hC, 2'h0, 1'b0, 16'h1000, 4'h1, 2'h1, 1, 4'hC);
    step(0, 0, 4'h1, 2'h1, 1'b1, 16'h0000, 4'h0, 2'h0, 0, 4'hC);
    @(negedge clk);
    enab = 1'b0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
